// File: rtl/vga_layer_compositor.sv
// VGA timing generator and fixed-priority N-layer compositor with PicoBlaze-written,
// frame-synchronised colour registers and alarm-driven layer blinking.
module vga_layer_compositor #(
  parameter int       H_ACTIVE     = 640,
  parameter int       H_FP         = 16,
  parameter int       H_SYNC       = 96,
  parameter int       H_BP         = 48,
  parameter int       V_ACTIVE     = 480,
  parameter int       V_FP         = 10,
  parameter int       V_SYNC       = 2,
  parameter int       V_BP         = 33,
  parameter logic     SYNC_POL     = 1'b0,
  parameter int       N_LAYERS     = 4,
  parameter int       LAYER_LAT    = 1,
  parameter logic [7:0] PORT_BASE  = 8'h10,
  parameter int       BLINK_FRAMES = 30
) (
  input  logic                reloj,
  input  logic                resetM,
  input  logic                pix_en,
  input  logic [7:0]          port_id,
  input  logic                write_strobe,
  input  logic [7:0]          out_port,
  input  logic [N_LAYERS-1:0] layer_bit,
  input  logic                alarm_active,
  output logic [9:0]          Qh,
  output logic [9:0]          Qv,
  output logic                H_Syncreg,
  output logic                V_Syncreg,
  output logic                video_on,
  output logic                frame_start,
  output logic [3:0]          R,
  output logic [3:0]          G,
  output logic [3:0]          B
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int CNT_W    = $clog2(BLINK_FRAMES + 1);

  function automatic logic [11:0] expand_rgb332(input logic [7:0] c);
    return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
  endfunction

  logic                h_last_s;
  logic                v_last_s;
  logic [2:0]          flags_s;
  logic [2:0]          flags_dly_s;
  logic [7:0]          off_s;
  logic                wr_bg_s;
  logic [N_LAYERS-1:0] wr_col_s;
  logic                wr_en_s;
  logic                wr_blink_s;
  logic [7:0]          bg_stg_r;
  logic [7:0]          col_stg_r [N_LAYERS];
  logic [N_LAYERS-1:0] en_stg_r;
  logic [N_LAYERS-1:0] blink_stg_r;
  logic [7:0]          bg_sh_r;
  logic [7:0]          col_sh_r [N_LAYERS];
  logic [N_LAYERS-1:0] en_sh_r;
  logic [N_LAYERS-1:0] blink_sh_r;
  logic [CNT_W-1:0]    blink_cnt_r;
  logic                blink_phase_r;
  logic [N_LAYERS-1:0] vis_s;
  logic [7:0]          pix_col_s;
  logic [11:0]         rgb_s;

  assign h_last_s = (Qh == 10'(H_TOTAL - 1));
  assign v_last_s = (Qv == 10'(V_TOTAL - 1));

  // Flags are kept active-high here; polarity is applied at the output register.
  assign flags_s = {(Qh >= 10'(HS_START)) && (Qh <= 10'(HS_END)),
                    (Qv >= 10'(VS_START)) && (Qv <= 10'(VS_END)),
                    (Qh < 10'(H_ACTIVE)) && (Qv < 10'(V_ACTIVE))};

  // Scan counters and frame-start pulse
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      Qh          <= 10'd0;
      Qv          <= 10'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en & h_last_s & v_last_s;
      if (pix_en) begin
        if (h_last_s) begin
          Qh <= 10'd0;
          if (v_last_s) Qv <= 10'd0;
          else          Qv <= Qv + 10'd1;
        end else begin
          Qh <= Qh + 10'd1;
        end
      end
    end
  end

  generate
    if (LAYER_LAT == 0) begin : g_no_dly
      assign flags_dly_s = flags_s;
    end else begin : g_dly
      logic [2:0] pipe_r [LAYER_LAT];

      // Timing flags delayed to match the layer source latency
      always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
          for (int k = 0; k < LAYER_LAT; k++) pipe_r[k] <= 3'b000;
        end else if (pix_en) begin
          pipe_r[0] <= flags_s;
          for (int k = 1; k < LAYER_LAT; k++) pipe_r[k] <= pipe_r[k-1];
        end
      end

      assign flags_dly_s = pipe_r[LAYER_LAT-1];
    end
  endgenerate

  assign off_s = port_id - PORT_BASE;

  // Port address decode into per-register write enables
  always_comb begin
    wr_col_s   = {N_LAYERS{1'b0}};
    wr_bg_s    = write_strobe & (off_s == 8'd0);
    wr_en_s    = write_strobe & (off_s == 8'(N_LAYERS + 1));
    wr_blink_s = write_strobe & (off_s == 8'(N_LAYERS + 2));
    for (int i = 0; i < N_LAYERS; i++) begin
      wr_col_s[i] = write_strobe & (off_s == 8'(i + 1));
    end
  end

  // Staging registers take CPU writes; shadows copy them once per frame
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      bg_stg_r    <= 8'h00;
      en_stg_r    <= {N_LAYERS{1'b1}};
      blink_stg_r <= {N_LAYERS{1'b0}};
      bg_sh_r     <= 8'h00;
      en_sh_r     <= {N_LAYERS{1'b1}};
      blink_sh_r  <= {N_LAYERS{1'b0}};
      for (int i = 0; i < N_LAYERS; i++) begin
        col_stg_r[i] <= 8'hFF;
        col_sh_r[i]  <= 8'hFF;
      end
    end else begin
      if (wr_bg_s)    bg_stg_r    <= out_port;
      if (wr_en_s)    en_stg_r    <= out_port[N_LAYERS-1:0];
      if (wr_blink_s) blink_stg_r <= out_port[N_LAYERS-1:0];
      for (int i = 0; i < N_LAYERS; i++) begin
        if (wr_col_s[i]) col_stg_r[i] <= out_port;
      end
      // Shadows sample the pre-write staging value, so a coincident write waits a frame
      if (frame_start) begin
        bg_sh_r    <= bg_stg_r;
        en_sh_r    <= en_stg_r;
        blink_sh_r <= blink_stg_r;
        for (int i = 0; i < N_LAYERS; i++) col_sh_r[i] <= col_stg_r[i];
      end
    end
  end

  // Blink frame counter and phase, held cleared while the alarm is off
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      blink_cnt_r   <= {CNT_W{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (!alarm_active) begin
      blink_cnt_r   <= {CNT_W{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt_r == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_r   <= {CNT_W{1'b0}};
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + CNT_W'(1);
      end
    end
  end

  // Gating the phase with alarm_active makes layers reappear on the very next pixel
  assign vis_s = layer_bit & en_sh_r &
                 ~(blink_sh_r & {N_LAYERS{blink_phase_r & alarm_active}});

  // Priority select: lowest-index visible layer overrides all others
  always_comb begin
    pix_col_s = bg_sh_r;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      pix_col_s = vis_s[i] ? col_sh_r[i] : pix_col_s;
    end
  end

  assign rgb_s = expand_rgb332(pix_col_s);

  // Output register aligning colour with the delayed sync and active flags
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      H_Syncreg <= ~SYNC_POL;
      V_Syncreg <= ~SYNC_POL;
      video_on  <= 1'b0;
      R         <= 4'h0;
      G         <= 4'h0;
      B         <= 4'h0;
    end else if (pix_en) begin
      H_Syncreg <= flags_dly_s[2] ? SYNC_POL : ~SYNC_POL;
      V_Syncreg <= flags_dly_s[1] ? SYNC_POL : ~SYNC_POL;
      video_on  <= flags_dly_s[0];
      if (flags_dly_s[0]) begin
        R <= rgb_s[11:8];
        G <= rgb_s[7:4];
        B <= rgb_s[3:0];
      end else begin
        R <= 4'h0;
        G <= 4'h0;
        B <= 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor on a shrunken 16x8 raster (128 cycles/frame).
module tb_vga_layer_compositor;

  logic       reloj = 1'b0;
  logic       resetM = 1'b0;
  logic       pix_en = 1'b1;
  logic [7:0] port_id = 8'h00;
  logic       write_strobe = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic [3:0] layer_bit = 4'b0000;
  logic       alarm_active = 1'b0;
  logic [9:0] Qh, Qv;
  logic       H_Syncreg, V_Syncreg, video_on, frame_start;
  logic [3:0] R, G, B;

  int errors = 0;
  int checks = 0;

  vga_layer_compositor #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .N_LAYERS(4), .LAYER_LAT(1),
    .PORT_BASE(8'h10), .BLINK_FRAMES(2)
  ) dut (
    .reloj(reloj), .resetM(resetM), .pix_en(pix_en),
    .port_id(port_id), .write_strobe(write_strobe), .out_port(out_port),
    .layer_bit(layer_bit), .alarm_active(alarm_active),
    .Qh(Qh), .Qv(Qv), .H_Syncreg(H_Syncreg), .V_Syncreg(V_Syncreg),
    .video_on(video_on), .frame_start(frame_start), .R(R), .G(G), .B(B)
  );

  always #5 reloj = ~reloj;

  typedef struct {
    int          h;
    int          v;
    logic [3:0]  lb;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        von;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_pos(input int h, input int v);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge reloj);
      if (Qh == 10'(h) && Qv == 10'(v)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_pos(%0d,%0d): got timeout expected position", h, v);
    end
  endtask

  task automatic wait_fs();
    bit found;
    found = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge reloj);
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_fs: got timeout expected frame_start");
    end
  endtask

  // Drive a write starting at the current negedge
  task automatic wr_now(input logic [7:0] a, input logic [7:0] d);
    port_id = a;
    out_port = d;
    write_strobe = 1'b1;
    @(negedge reloj);
    write_strobe = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge reloj);
    wr_now(a, d);
  endtask

  task automatic chk_pix(input string name, input int h, input int v, input logic [11:0] exp);
    wait_pos(h, v);
    repeat (2) @(negedge reloj);
    chk(name, {R, G, B}, exp);
  endtask

  initial begin
    int fs_cnt;

    vecs[0]  = '{2,  1, 4'b0011, 12'hF00, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{5,  1, 4'b0010, 12'h0F0, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{9,  1, 4'b1111, 12'h000, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{12, 1, 4'b0001, 12'h000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{15, 1, 4'b0001, 12'h000, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{4,  2, 4'b0100, 12'h445, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{7,  2, 4'b1000, 12'h99A, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{10, 2, 4'b0001, 12'h000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{13, 2, 4'b0001, 12'h000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{0,  3, 4'b1100, 12'h445, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{3,  3, 4'b0000, 12'h00F, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{6,  3, 4'b1111, 12'hF00, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{0,  4, 4'b0001, 12'h000, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{0,  5, 4'b0001, 12'h000, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{15, 6, 4'b0001, 12'h000, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{0,  7, 4'b0001, 12'h000, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{11, 4, 4'b0001, 12'h000, 1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge reloj);
    chk("rst_qh", Qh, 0);
    chk("rst_qv", Qv, 0);
    chk("rst_rgb", {R, G, B}, 0);
    chk("rst_von", video_on, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_syncs", {H_Syncreg, V_Syncreg}, 2'b11);
    resetM = 1'b1;

    wr(8'h10, 8'h03);
    wr(8'h11, 8'hE0);
    wr(8'h12, 8'h1C);
    wr(8'h13, 8'h49);
    wr(8'h14, 8'h92);
    wr(8'h20, 8'h55);

    // Frame start position and period
    wait_fs();
    chk("fs_pos", {Qh, Qv}, 0);
    fs_cnt = 0;
    for (int n = 0; n < 256; n++) begin
      @(negedge reloj);
      if (frame_start === 1'b1) fs_cnt++;
    end
    chk("fs_count_2frames", fs_cnt, 2);

    // Table-driven composition and timing
    for (int i = 0; i < 17; i++) begin
      layer_bit = vecs[i].lb;
      wait_pos(vecs[i].h, vecs[i].v);
      repeat (2) @(negedge reloj);
      chk($sformatf("vec%0d_rgb", i), {R, G, B}, vecs[i].rgb);
      chk($sformatf("vec%0d_hs", i), H_Syncreg, vecs[i].hs);
      chk($sformatf("vec%0d_vs", i), V_Syncreg, vecs[i].vs);
      chk($sformatf("vec%0d_von", i), video_on, vecs[i].von);
    end

    // Line wrap
    wait_pos(15, 3);
    @(negedge reloj);
    chk("wrap_qh", Qh, 0);
    chk("wrap_qv", Qv, 4);

    // pix_en low freezes the scan
    wait_pos(3, 2);
    pix_en = 1'b0;
    repeat (5) @(negedge reloj);
    chk("hold_qh", Qh, 3);
    pix_en = 1'b1;
    @(negedge reloj);
    chk("resume_qh", Qh, 4);

    // Mid-frame write holds until next frame
    layer_bit = 4'b0001;
    wait_pos(0, 1);
    wr_now(8'h11, 8'hFC);
    chk_pix("dbuf_old", 5, 2, 12'hF00);
    chk_pix("dbuf_new", 5, 2, 12'hFF0);

    // Write coincident with frame_start shows one frame later
    wait_fs();
    wr_now(8'h11, 8'h1C);
    chk_pix("fswr_held", 2, 1, 12'hFF0);
    chk_pix("fswr_next", 2, 1, 12'h0F0);

    // Blink: 2 frames visible, 2 hidden
    wr(8'h16, 8'h01);
    wait_fs();
    @(negedge reloj);
    alarm_active = 1'b1;
    for (int k = 0; k < 7; k++) begin
      chk_pix($sformatf("blink_f%0d", k), 2, 1, (((k / 2) % 2) == 1) ? 12'h00F : 12'h0F0);
    end
    alarm_active = 1'b0;
    @(negedge reloj);
    chk("blink_drop", {R, G, B}, 12'h0F0);

    // Asynchronous reset mid-line
    wait_pos(5, 2);
    #1 resetM = 1'b0;
    #1;
    chk("mrst_qh", Qh, 0);
    chk("mrst_qv", Qv, 0);
    chk("mrst_rgb", {R, G, B}, 0);
    chk("mrst_von", video_on, 0);
    chk("mrst_syncs", {H_Syncreg, V_Syncreg}, 2'b11);
    repeat (3) @(negedge reloj);
    resetM = 1'b1;
    chk("mrst_rel_qh", Qh, 0);
    @(negedge reloj);
    chk("mrst_count_qh", Qh, 1);
    layer_bit = 4'b0001;
    chk_pix("mrst_col_ff", 2, 1, 12'hFFF);
    layer_bit = 4'b0000;
    chk_pix("mrst_bg_00", 3, 1, 12'h000);
    chk("mrst_bg_von", video_on, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
